// File: rtl/register_file_param_if.sv
// Register file port bundle: write, reserve, clear and two read ports.
// Master drives requests/addresses; slave returns ready and read results.
interface register_file_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              clear_req;
    logic              rf_ready;
    logic              reg_write_en;
    logic [ADDR_W-1:0] reg_write_dest;
    logic [DATA_W-1:0] reg_write_data;
    logic              reg_reserve_en;
    logic [ADDR_W-1:0] reg_reserve_dest;
    logic [ADDR_W-1:0] reg_read_addr_1;
    logic [ADDR_W-1:0] reg_read_addr_2;
    logic [DATA_W-1:0] reg_read_data_1;
    logic [DATA_W-1:0] reg_read_data_2;
    logic              reg_read_pending_1;
    logic              reg_read_pending_2;

    modport master (
        output clear_req,
        output reg_write_en,
        output reg_write_dest,
        output reg_write_data,
        output reg_reserve_en,
        output reg_reserve_dest,
        output reg_read_addr_1,
        output reg_read_addr_2,
        input  rf_ready,
        input  reg_read_data_1,
        input  reg_read_data_2,
        input  reg_read_pending_1,
        input  reg_read_pending_2
    );

    modport slave (
        input  clear_req,
        input  reg_write_en,
        input  reg_write_dest,
        input  reg_write_data,
        input  reg_reserve_en,
        input  reg_reserve_dest,
        input  reg_read_addr_1,
        input  reg_read_addr_2,
        output rf_ready,
        output reg_read_data_1,
        output reg_read_data_2,
        output reg_read_pending_1,
        output reg_read_pending_2
    );
endinterface

// File: rtl/register_file_param.sv
// Register file with pending scoreboard and a run-time clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the reads.
module register_file_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input logic                  clk,
    input logic                  rst,
    register_file_param_if.slave rf
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DEPTH-1:0]  pending;
    logic [DATA_W-1:0] mem [DEPTH];

    logic run;
    logic wr_ok;
    logic rsv_ok;

    assign run = (state == RUN);
    assign rf.rf_ready = run;

    // A clear request on the same edge swallows any write or reserve.
    assign wr_ok = run && !rf.clear_req && rf.reg_write_en
                   && (rf.reg_write_dest != '0);
    assign rsv_ok = run && !rf.clear_req && rf.reg_reserve_en
                    && (rf.reg_reserve_dest != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            pending <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + ADDR_W'(1);
                    if (clr_ptr == ADDR_W'(DEPTH - 1))
                        state <= RUN;
                end
                RUN: begin
                    if (rf.clear_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                        pending <= '0;
                    end else begin
                        if (wr_ok)
                            pending[rf.reg_write_dest] <= 1'b0;
                        if (rsv_ok)
                            pending[rf.reg_reserve_dest] <= 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Data array has no reset; the CLEAR sweep zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run)
                mem[clr_ptr] <= '0;
            else if (wr_ok)
                mem[rf.reg_write_dest] <= rf.reg_write_data;
        end
    end

    logic [1:0][ADDR_W-1:0] ra;
    logic [1:0][DATA_W-1:0] rd;
    logic [1:0]             rp;

    assign ra[0] = rf.reg_read_addr_1;
    assign ra[1] = rf.reg_read_addr_2;

    always_comb begin
        rd = '0;
        rp = '0;
        for (int i = 0; i < 2; i++) begin
            if (run && (ra[i] != '0)) begin
                rd[i] = mem[ra[i]];
                rp[i] = pending[ra[i]];
`ifdef REGFILE_BYPASS_EN
                if (rf.reg_write_en && (rf.reg_write_dest == ra[i])) begin
                    rd[i] = rf.reg_write_data;
                    rp[i] = rf.reg_reserve_en
                            && (rf.reg_reserve_dest == ra[i]);
                end
`endif
            end
        end
    end

    assign rf.reg_read_data_1    = rd[0];
    assign rf.reg_read_data_2    = rd[1];
    assign rf.reg_read_pending_1 = rp[0];
    assign rf.reg_read_pending_2 = rp[1];
endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: vector table plus sweep,
// clear and reset sequences on a default and a 32x16 instance.
module tb_register_file_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_b = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    register_file_param_if #(.DATA_W(16), .ADDR_W(3)) si ();
    register_file_param_if #(.DATA_W(32), .ADDR_W(4)) bi ();

    register_file_param #(.DATA_W(16), .ADDR_W(3)) u_dut (
        .clk(clk),
        .rst(rst),
        .rf (si)
    );

    register_file_param #(.DATA_W(32), .ADDR_W(4)) u_big (
        .clk(clk),
        .rst(rst_b),
        .rf (bi)
    );

    typedef struct {
        logic        we;
        logic [2:0]  wd;
        logic [15:0] wv;
        logic        re;
        logic [2:0]  rv;
        logic [2:0]  a1;
        logic [2:0]  a2;
        logic [15:0] e1;
        logic        ep1;
        logic [15:0] e2;
        logic        ep2;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        si.clear_req        = 1'b0;
        si.reg_write_en     = 1'b0;
        si.reg_write_dest   = '0;
        si.reg_write_data   = '0;
        si.reg_reserve_en   = 1'b0;
        si.reg_reserve_dest = '0;
        si.reg_read_addr_1  = '0;
        si.reg_read_addr_2  = '0;
    endtask

    task automatic rd(input logic [2:0] a1, input logic [2:0] a2);
        si.reg_read_addr_1 = a1;
        si.reg_read_addr_2 = a2;
        #1;
    endtask

    task automatic wr(input logic [2:0] d, input logic [15:0] v);
        si.reg_write_en   = 1'b1;
        si.reg_write_dest = d;
        si.reg_write_data = v;
    endtask

    task automatic sweep(input bit big, input int n, input string nm);
        int cnt = 0;
        while (((big ? bi.rf_ready : si.rf_ready) == 1'b0)
               && cnt < n + 4) begin
            tick();
            cnt++;
        end
        chk(nm, 32'(cnt), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        bi.clear_req        = 1'b0;
        bi.reg_write_en     = 1'b0;
        bi.reg_write_dest   = '0;
        bi.reg_write_data   = '0;
        bi.reg_reserve_en   = 1'b0;
        bi.reg_reserve_dest = '0;
        bi.reg_read_addr_1  = '0;
        bi.reg_read_addr_2  = '0;

        //          we wd wv       re rv a1 a2 e1       p1 e2       p2
        vt[0]  = '{1, 3, 16'hBEEF, 0, 0, 1, 2, 16'h0000, 0, 16'h0000, 0};
        vt[1]  = '{1, 0, 16'h1234, 0, 0, 3, 0, 16'hBEEF, 0, 16'h0000, 0};
        vt[2]  = '{0, 0, 16'h0000, 0, 0, 3, 3, 16'hBEEF, 0, 16'hBEEF, 0};
        vt[3]  = '{0, 0, 16'h0000, 1, 5, 5, 0, 16'h0000, 0, 16'h0000, 0};
        vt[4]  = '{0, 0, 16'h0000, 0, 0, 5, 3, 16'h0000, 1, 16'hBEEF, 0};
        vt[5]  = '{1, 5, 16'h00A5, 0, 0, 3, 0, 16'hBEEF, 0, 16'h0000, 0};
        vt[6]  = '{0, 0, 16'h0000, 0, 0, 5, 5, 16'h00A5, 0, 16'h00A5, 0};
        vt[7]  = '{1, 6, 16'h1357, 1, 6, 5, 3, 16'h00A5, 0, 16'hBEEF, 0};
        vt[8]  = '{0, 0, 16'h0000, 0, 0, 6, 5, 16'h1357, 1, 16'h00A5, 0};
        vt[9]  = '{0, 0, 16'h0000, 1, 0, 6, 6, 16'h1357, 1, 16'h1357, 1};
        vt[10] = '{0, 0, 16'h0000, 0, 0, 0, 6, 16'h0000, 0, 16'h1357, 1};
        vt[11] = '{1, 6, 16'h2468, 0, 0, 0, 5, 16'h0000, 0, 16'h00A5, 0};
        vt[12] = '{0, 0, 16'h0000, 0, 0, 6, 7, 16'h2468, 0, 16'h0000, 0};

        // Reset held two edges, then an 8-edge sweep.
        tick();
        tick();
        rd(3'd1, 3'd2);
        chk("rst_ready", 32'(si.rf_ready), 32'd0);
        chk("rst_d1", 32'(si.reg_read_data_1), 32'd0);
        chk("rst_p2", 32'(si.reg_read_pending_2), 32'd0);
        rst = 1'b0;
        sweep(1'b0, 8, "init_sweep");
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 3'(7 - i));
            chk($sformatf("init_d1_r%0d", i),
                32'(si.reg_read_data_1), 32'd0);
            chk($sformatf("init_d2_r%0d", 7 - i),
                32'(si.reg_read_data_2), 32'd0);
            chk($sformatf("init_p1_r%0d", i),
                32'(si.reg_read_pending_1), 32'd0);
        end

        for (int i = 0; i < 13; i++) begin
            si.reg_write_en     = vt[i].we;
            si.reg_write_dest   = vt[i].wd;
            si.reg_write_data   = vt[i].wv;
            si.reg_reserve_en   = vt[i].re;
            si.reg_reserve_dest = vt[i].rv;
            rd(vt[i].a1, vt[i].a2);
            chk($sformatf("v%0d_rdy", i), 32'(si.rf_ready), 32'd1);
            chk($sformatf("v%0d_d1", i),
                32'(si.reg_read_data_1), 32'(vt[i].e1));
            chk($sformatf("v%0d_p1", i),
                32'(si.reg_read_pending_1), 32'(vt[i].ep1));
            chk($sformatf("v%0d_d2", i),
                32'(si.reg_read_data_2), 32'(vt[i].e2));
            chk($sformatf("v%0d_p2", i),
                32'(si.reg_read_pending_2), 32'(vt[i].ep2));
            tick();
        end
        idle();

        // Same-cycle read of the register being written.
        wr(3'd2, 16'h1111);
        tick();
        wr(3'd2, 16'h2222);
        rd(3'd2, 3'd2);
        chk("byp_d1", 32'(si.reg_read_data_1),
            BYP ? 32'h2222 : 32'h1111);
        chk("byp_p1", 32'(si.reg_read_pending_1), 32'd0);
        tick();
        idle();
        rd(3'd2, 3'd0);
        chk("byp_after", 32'(si.reg_read_data_1), 32'h2222);

        // Run-time clear swallows a same-edge write; CLEAR ignores traffic.
        si.reg_reserve_en   = 1'b1;
        si.reg_reserve_dest = 3'd5;
        tick();
        idle();
        si.clear_req = 1'b1;
        wr(3'd4, 16'hFFFF);
        rd(3'd4, 3'd5);
        chk("clr_pre_rdy", 32'(si.rf_ready), 32'd1);
        chk("clr_pre_p5", 32'(si.reg_read_pending_2), 32'd1);
        tick();
        idle();
        for (int k = 0; k < 8; k++) begin
            if (k >= 3) begin
                wr(3'd1, 16'h7777);
                si.reg_reserve_en   = 1'b1;
                si.reg_reserve_dest = 3'd2;
                si.clear_req        = 1'b1;
            end
            rd(3'd3, 3'd5);
            chk($sformatf("clr_rdy_%0d", k), 32'(si.rf_ready), 32'd0);
            chk($sformatf("clr_d1_%0d", k),
                32'(si.reg_read_data_1), 32'd0);
            tick();
        end
        idle();
        rd(3'd4, 3'd1);
        chk("clr_done_rdy", 32'(si.rf_ready), 32'd1);
        chk("clr_r4", 32'(si.reg_read_data_1), 32'd0);
        chk("clr_r1", 32'(si.reg_read_data_2), 32'd0);
        rd(3'd5, 3'd2);
        chk("clr_p5", 32'(si.reg_read_pending_1), 32'd0);
        chk("clr_p2", 32'(si.reg_read_pending_2), 32'd0);
        rd(3'd3, 3'd6);
        chk("clr_r3", 32'(si.reg_read_data_1), 32'd0);
        chk("clr_r6", 32'(si.reg_read_data_2), 32'd0);

        // Reset at sweep entry 4 restarts the full sweep.
        si.clear_req = 1'b1;
        tick();
        idle();
        for (int k = 0; k < 4; k++)
            tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep(1'b0, 8, "rst_mid_clear");

        // Reset mid-RUN drops data and pending state.
        wr(3'd3, 16'h5555);
        si.reg_reserve_en   = 1'b1;
        si.reg_reserve_dest = 3'd5;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rd(3'd3, 3'd5);
        chk("rst_run_rdy", 32'(si.rf_ready), 32'd0);
        chk("rst_run_d1", 32'(si.reg_read_data_1), 32'd0);
        rst = 1'b0;
        sweep(1'b0, 8, "rst_mid_run");
        rd(3'd3, 3'd5);
        chk("rst_run_r3", 32'(si.reg_read_data_1), 32'd0);
        chk("rst_run_p5", 32'(si.reg_read_pending_2), 32'd0);

        // Wide instance: 16-entry sweep and a 32-bit write.
        rst_b = 1'b0;
        sweep(1'b1, 16, "big_sweep");
        bi.reg_write_en   = 1'b1;
        bi.reg_write_dest = 4'd15;
        bi.reg_write_data = 32'hDEADBEEF;
        tick();
        bi.reg_write_en    = 1'b0;
        bi.reg_read_addr_1 = 4'd15;
        bi.reg_read_addr_2 = 4'd14;
        #1;
        chk("big_r15", bi.reg_read_data_1, 32'hDEADBEEF);
        chk("big_r14", bi.reg_read_data_2, 32'd0);
        bi.reg_read_addr_2 = 4'd15;
        #1;
        chk("big_r15_p2", bi.reg_read_data_2, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, data width of each entry.
REQ-002 The block SHALL have parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port clear_req, input, 1, request a full array clear at run time.
REQ-006 The block SHALL have port rf_ready, output, 1, high when in RUN state.
REQ-007 The block SHALL have ports reg_write_en (1), reg_write_dest (ADDR_W) and reg_write_data (DATA_W), inputs, forming the synchronous write port.
REQ-008 The block SHALL have ports reg_reserve_en (1) and reg_reserve_dest (ADDR_W), inputs, which mark a register as pending (in-flight producer).
REQ-009 The block SHALL have ports reg_read_addr_1 and reg_read_addr_2, inputs, ADDR_W each, the read addresses.
REQ-010 The block SHALL have ports reg_read_data_1 and reg_read_data_2, outputs, DATA_W each, the combinational read data.
REQ-011 The block SHALL have ports reg_read_pending_1 and reg_read_pending_2, outputs, 1 each, the pending bit of the addressed register.

Function
REQ-012 States SHALL be CLEAR and RUN; rf_ready = (state == RUN).
REQ-013 In CLEAR, each edge SHALL write 0 to entry clr_ptr and increment clr_ptr; the edge that writes entry DEPTH-1 SHALL move the state to RUN.
REQ-014 In RUN, clear_req=1 at an edge SHALL move the state to CLEAR with clr_ptr=0 and all pending bits cleared; a write or reserve presented on that same edge SHALL be discarded.
REQ-015 In CLEAR, writes, reserves and clear_req SHALL be ignored, and both read data and pending outputs SHALL read 0.
REQ-016 In RUN, with reg_write_en=1 and a nonzero dest, entry dest SHALL take reg_write_data at the edge and pending[dest] SHALL clear.
REQ-017 In RUN, with reg_reserve_en=1 and a nonzero dest, pending[dest] SHALL set at the edge.
REQ-018 When a reserve and a write target the same dest on the same edge, the data SHALL be written and pending SHALL end set (reserve wins).
REQ-019 Entry 0 SHALL always read 0 with pending 0; writes and reserves to address 0 SHALL be discarded.
REQ-020 Read ports SHALL be combinational, with zero latency, and SHALL be independent; both ports may address the same entry.
REQ-021 Without bypass, a read of the address being written on the same cycle SHALL return the old value; the new value SHALL be visible after the edge.

Reset
REQ-022 rst=1 at an edge SHALL set state=CLEAR, clr_ptr=0, and all pending bits to 0; it SHALL NOT directly clear the data array, which is swept by CLEAR.
REQ-023 While rst=1 and after it, rf_ready SHALL be 0 and all read outputs SHALL be 0, until DEPTH edges with rst=0 have completed the sweep.
REQ-024 rst asserted mid-CLEAR or mid-RUN SHALL restart the sweep from entry 0.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN, when defined, SHALL make a RUN-state read of a nonzero address equal to the current reg_write_dest with reg_write_en=1 return reg_write_data combinationally and report pending 0 (unless a reserve to the same dest is also active, in which case it reports 1).
REQ-026 When REGFILE_BYPASS_EN is undefined, behaviour SHALL be per REQ-021, with no bypass path.

Verification
REQ-027 Default parameters; rst for 2 cycles, release -> rf_ready=0 for exactly 8 edges, then 1; reading all addresses gives 0x0000 with pending 0.
REQ-028 In RUN, write r3=0xBEEF and r0=0x1234 -> read_1(r3)=0xBEEF, read_2(r0)=0x0000, the same value on both ports when both address r3.
REQ-029 Reserve r5 -> pending_1(r5)=1; write r5=0x00A5 next cycle -> pending 0 and data 0x00A5; a same-edge reserve and write to r6 -> pending 1 and data updated.
REQ-030 With r2=0x1111, write r2=0x2222 while reading r2 -> 0x1111 without REGFILE_BYPASS_EN, 0x2222 with it; 0x2222 after the edge in both builds.
REQ-031 clear_req plus write r4=0xFFFF on the same edge -> write discarded, rf_ready low for 8 edges, r4 reads 0 afterwards; rst asserted at sweep entry 4 restarts a full 8-edge sweep.
REQ-032 DATA_W=32, ADDR_W=4 -> 16-edge sweep, and a write/read of 0xDEADBEEF to r15 passes.
